// File: rtl/uart_log_mux.sv
// N-channel byte logger: per-channel FIFOs drained round-robin as hex ASCII lines to one UART tx.
// Define LOG_MUX_TAG_EN to prefix every line with "<channel digit>:".
module uart_log_mux #(
    parameter int NUM_CH   = 2,
    parameter int FIFO_AW  = 3,
    parameter int IDLE_CLK = 20000,
    parameter int LINE_MAX = 16,
    parameter int CNT_BW   = 15
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [NUM_CH-1:0]   rx_en_i,
    input  logic [8*NUM_CH-1:0] rx_data_i,
    output logic                tx_en_o,
    output logic [7:0]          tx_data_o,
    input  logic                tx_busy_i,
    output logic [NUM_CH-1:0]   ovf_o,
    input  logic                ovf_clr_i
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CHW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [7:0]        LINE_LAST = 8'(LINE_MAX);
    localparam logic [CNT_BW-1:0] IDLE_LAST = CNT_BW'(IDLE_CLK - 1);
    localparam logic [CHW-1:0]    CH_LAST   = CHW'(NUM_CH - 1);

    typedef enum logic [3:0] {
        S_IDLE,
`ifdef LOG_MUX_TAG_EN
        S_TAG,
        S_COLON,
`endif
        S_HI,
        S_LO,
        S_SP,
        S_WAITD,
        S_CR,
        S_LF
    } state_e;

    logic [7:0]        mem_q [NUM_CH][DEPTH];
    logic [7:0]        mem_d [NUM_CH][DEPTH];
    logic [FIFO_AW:0]  wr_q [NUM_CH];
    logic [FIFO_AW:0]  wr_d [NUM_CH];
    logic [FIFO_AW:0]  rd_q [NUM_CH];
    logic [FIFO_AW:0]  rd_d [NUM_CH];
    logic [NUM_CH-1:0] empty, full;
    logic [NUM_CH-1:0] ovf_q, ovf_d;

    state_e            state_q, state_d;
    logic [CHW-1:0]    ch_q, ch_d, rr_q, rr_d;
    logic [7:0]        bytes_q, bytes_d;
    logic [CNT_BW-1:0] timer_q, timer_d;
    logic [7:0]        data_q, data_d;
    logic [1:0]        holdoff_q, holdoff_d;
    logic              tx_en_q, tx_en_d;
    logic [7:0]        tx_data_q, tx_data_d;

    logic              pop, emit, can_emit, found, pop_c;
    logic [7:0]        emit_char, head;
    logic [CHW-1:0]    sel, cand;
    int unsigned       idx;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    assign head      = mem_q[ch_q][rd_q[ch_q][FIFO_AW-1:0]];
    assign tx_en_o   = tx_en_q;
    assign tx_data_o = tx_data_q;
    assign ovf_o     = ovf_q;

    always_comb begin
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            empty[c] = (wr_q[c] == rd_q[c]);
            full[c]  = (wr_q[c][FIFO_AW] != rd_q[c][FIFO_AW]) &&
                       (wr_q[c][FIFO_AW-1:0] == rd_q[c][FIFO_AW-1:0]);
        end
    end

    // A full FIFO still accepts a push when the locked channel pops it in the same cycle.
    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        ovf_d = ovf_clr_i ? '0 : ovf_q;
        pop_c = 1'b0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            pop_c = pop && (ch_q == CHW'(c));
            if (pop_c) begin
                rd_d[c] = rd_q[c] + 1'b1;
            end
            if (rx_en_i[c]) begin
                if (!full[c] || pop_c) begin
                    mem_d[c][wr_q[c][FIFO_AW-1:0]] = rx_data_i[8*c +: 8];
                    wr_d[c] = wr_q[c] + 1'b1;
                end else begin
                    ovf_d[c] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        rr_d      = rr_q;
        bytes_d   = bytes_q;
        timer_d   = timer_q;
        data_d    = data_q;
        pop       = 1'b0;
        emit      = 1'b0;
        emit_char = '0;
        found     = 1'b0;
        sel       = rr_q;
        cand      = '0;
        idx       = 0;
        can_emit  = !tx_busy_i && !tx_en_q && (holdoff_q == 2'd0);

        for (int unsigned i = 0; i < NUM_CH; i++) begin
            idx = 32'(rr_q) + i;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            cand = CHW'(idx);
            if (!found && !empty[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (found) begin
                    ch_d    = sel;
                    bytes_d = '0;
`ifdef LOG_MUX_TAG_EN
                    state_d = S_TAG;
`else
                    state_d = S_HI;
`endif
                end
            end
`ifdef LOG_MUX_TAG_EN
            S_TAG: if (can_emit) begin
                emit      = 1'b1;
                emit_char = 8'h30 + 8'(ch_q);
                state_d   = S_COLON;
            end
            S_COLON: if (can_emit) begin
                emit      = 1'b1;
                emit_char = 8'h3A;
                state_d   = S_HI;
            end
`endif
            S_HI: if (can_emit) begin
                pop       = 1'b1;
                data_d    = head;
                emit      = 1'b1;
                emit_char = hex_char(head[7:4]);
                state_d   = S_LO;
            end
            S_LO: if (can_emit) begin
                emit      = 1'b1;
                emit_char = hex_char(data_q[3:0]);
                state_d   = S_SP;
            end
            S_SP: if (can_emit) begin
                emit      = 1'b1;
                emit_char = 8'h20;
                bytes_d   = bytes_q + 8'd1;
                timer_d   = '0;
                if (bytes_d == LINE_LAST) begin
                    state_d = S_CR;
                end else if (!empty[ch_q]) begin
                    state_d = S_HI;
                end else begin
                    state_d = S_WAITD;
                end
            end
            S_WAITD: begin
                if (!empty[ch_q]) begin
                    timer_d = '0;
                    state_d = S_HI;
                end else if (timer_q == IDLE_LAST) begin
                    timer_d = '0;
                    state_d = S_CR;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_CR: if (can_emit) begin
                emit      = 1'b1;
                emit_char = 8'h0D;
                state_d   = S_LF;
            end
            S_LF: if (can_emit) begin
                emit      = 1'b1;
                emit_char = 8'h0A;
                rr_d      = (ch_q == CH_LAST) ? '0 : ch_q + 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        tx_en_d   = emit;
        tx_data_d = emit ? emit_char : tx_data_q;
        // Holdoff starts on the tx_en_o cycle, giving the transmitter time to raise busy.
        holdoff_d = tx_en_q ? 2'd2 : ((holdoff_q != 2'd0) ? holdoff_q - 2'd1 : 2'd0);
    end

    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q      <= '{default: '0};
            rd_q      <= '{default: '0};
            ovf_q     <= '0;
            state_q   <= S_IDLE;
            ch_q      <= '0;
            rr_q      <= '0;
            bytes_q   <= '0;
            timer_q   <= '0;
            data_q    <= '0;
            holdoff_q <= '0;
            tx_en_q   <= 1'b0;
            tx_data_q <= '0;
        end else begin
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            ovf_q     <= ovf_d;
            state_q   <= state_d;
            ch_q      <= ch_d;
            rr_q      <= rr_d;
            bytes_q   <= bytes_d;
            timer_q   <= timer_d;
            data_q    <= data_d;
            holdoff_q <= holdoff_d;
            tx_en_q   <= tx_en_d;
            tx_data_q <= tx_data_d;
        end
    end

endmodule

// File: tb/tb_uart_log_mux.sv
// Bench for uart_log_mux: a character-stream model (round-robin lines of hex text) checked
// against every tx_en_o pulse, plus literal expectations for the basic line formats.
module tb_uart_log_mux;

    localparam int NCH   = 3;
    localparam int AW    = 3;
    localparam int DEPTH = 1 << AW;
    localparam int IDLE  = 40;
    localparam int LMAX  = 5;
    localparam int CBW   = 6;
`ifdef LOG_MUX_TAG_EN
    localparam int TAGN = 2;
`else
    localparam int TAGN = 0;
`endif

    logic             clk_i = 1'b0;
    logic             rst_ni = 1'b1;
    logic [NCH-1:0]   rx_en_i = '0;
    logic [8*NCH-1:0] rx_data_i = '0;
    logic             tx_en_o;
    logic [7:0]       tx_data_o;
    logic             tx_busy_i = 1'b1;
    logic [NCH-1:0]   ovf_o;
    logic             ovf_clr_i = 1'b0;

    uart_log_mux #(
        .NUM_CH  (NCH),
        .FIFO_AW (AW),
        .IDLE_CLK(IDLE),
        .LINE_MAX(LMAX),
        .CNT_BW  (CBW)
    ) dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .rx_en_i  (rx_en_i),
        .rx_data_i(rx_data_i),
        .tx_en_o  (tx_en_o),
        .tx_data_o(tx_data_o),
        .tx_busy_i(tx_busy_i),
        .ovf_o    (ovf_o),
        .ovf_clr_i(ovf_clr_i)
    );

    always #5 clk_i = ~clk_i;

    int         checks = 0;
    int         failures = 0;
    logic [7:0] exp_q[$];
    logic [7:0] log_q[$];
    int         log_t[$];
    int         cyc = 0;
    int         n_rx = 0;
    int         since_en = 100;
    logic       prev_busy = 1'b1;
    logic [7:0] pend_mem [NCH][512];
    int         pend_h [NCH];
    int         pend_t [NCH];
    int         rr_m = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] hexc(input logic [3:0] n);
        if (n < 4'd10) return 8'h30 + 8'(n);
        return 8'h41 + 8'(n) - 8'd10;
    endfunction

    // Reference: visit non-empty channels round-robin from the pointer, each visit one line of
    // at most LMAX bytes, always closed by CR LF; pointer moves past the channel served.
    function automatic void model_render();
        int l;
        int n;
        logic [7:0] b;
        do begin
            l = -1;
            for (int i = 0; i < NCH; i++) begin
                int c;
                c = (rr_m + i) % NCH;
                if (l < 0 && pend_t[c] != pend_h[c]) l = c;
            end
            if (l >= 0) begin
`ifdef LOG_MUX_TAG_EN
                exp_q.push_back(8'(48 + l));
                exp_q.push_back(8'h3A);
`endif
                n = pend_t[l] - pend_h[l];
                if (n > LMAX) n = LMAX;
                for (int j = 0; j < n; j++) begin
                    b = pend_mem[l][pend_h[l]];
                    pend_h[l]++;
                    exp_q.push_back(hexc(b[7:4]));
                    exp_q.push_back(hexc(b[3:0]));
                    exp_q.push_back(8'h20);
                end
                exp_q.push_back(8'h0D);
                exp_q.push_back(8'h0A);
                rr_m = (l + 1) % NCH;
            end
        end while (l >= 0);
    endfunction

    always @(negedge clk_i) begin
        cyc++;
        if (!rst_ni) begin
            since_en  = 100;
            prev_busy = 1'b1;
        end else begin
            if (tx_en_o) begin
                chk("tx_after_busy_low", prev_busy, 0);
                chk("tx_spacing_ge4", (since_en >= 4), 1);
                since_en = 0;
                n_rx++;
                log_q.push_back(tx_data_o);
                log_t.push_back(cyc);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_tx: got char %02h, expected no character", tx_data_o);
                end else begin
                    chk("tx_char", tx_data_o, exp_q.pop_front());
                end
            end
            since_en++;
            prev_busy = tx_busy_i;
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_model();
        exp_q.delete();
        log_q.delete();
        log_t.delete();
        for (int c = 0; c < NCH; c++) begin
            pend_h[c] = 0;
            pend_t[c] = 0;
        end
        rr_m = 0;
    endtask

    task automatic do_reset();
        rst_ni    = 1'b0;
        rx_en_i   = '0;
        ovf_clr_i = 1'b0;
        tx_busy_i = 1'b1;
        #1;
        chk("reset_tx_en", tx_en_o, 0);
        chk("reset_tx_data", tx_data_o, 8'h00);
        chk("reset_ovf", ovf_o, 0);
        clear_model();
        repeat (2) tick();
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic load(input int cnt[NCH], input bit rnd, input logic [7:0] first[NCH],
                        output logic [NCH-1:0] mask);
        int mx;
        mx   = 0;
        mask = '0;
        for (int c = 0; c < NCH; c++) begin
            if (cnt[c] > mx) mx = cnt[c];
            if (cnt[c] > DEPTH) mask[c] = 1'b1;
        end
        tx_busy_i = 1'b1;
        tick();
        for (int k = 0; k < mx; k++) begin
            for (int c = 0; c < NCH; c++) begin
                logic [7:0] b;
                b = rnd ? 8'($urandom) : first[c] + 8'(k);
                rx_en_i[c] = (k < cnt[c]);
                rx_data_i[8*c +: 8] = b;
                if (k < cnt[c] && k < DEPTH) begin
                    pend_mem[c][pend_t[c]] = b;
                    pend_t[c]++;
                end
            end
            tick();
        end
        rx_en_i = '0;
        chk("ovf_after_load", ovf_o, mask);
        model_render();
    endtask

    task automatic drain(input bit jitter, input int hold_after);
        int  k;
        int  nb;
        bit  held;
        k    = 0;
        held = 1'b0;
        while (exp_q.size() != 0 && k < 6000) begin
            if (!held && hold_after >= 0 && n_rx >= hold_after) begin
                held      = 1'b1;
                tx_busy_i = 1'b1;
                tick();
                tick();
                nb = n_rx;
                repeat (98) tick();
                chk("busy_hold_no_tx", n_rx, nb);
                k += 100;
            end
            tx_busy_i = jitter ? ($urandom_range(0, 3) == 0) : 1'b0;
            tick();
            k++;
        end
        chk("drain_complete", exp_q.size(), 0);
        tx_busy_i = 1'b0;
        repeat (10) tick();
        tx_busy_i = 1'b1;
    endtask

    task automatic pulse_clear();
        ovf_clr_i = 1'b1;
        tick();
        ovf_clr_i = 1'b0;
        chk("ovf_cleared", ovf_o, 0);
    endtask

`ifdef LOG_MUX_TAG_EN
    logic [7:0] lit1 [7]  = '{8'h30, 8'h3A, 8'h33, 8'h41, 8'h20, 8'h0D, 8'h0A};
    logic [7:0] lit2 [14] = '{8'h30, 8'h3A, 8'h30, 8'h31, 8'h20, 8'h0D, 8'h0A,
                              8'h31, 8'h3A, 8'h46, 8'h46, 8'h20, 8'h0D, 8'h0A};
`else
    logic [7:0] lit1 [5]  = '{8'h33, 8'h41, 8'h20, 8'h0D, 8'h0A};
    logic [7:0] lit2 [10] = '{8'h30, 8'h31, 8'h20, 8'h0D, 8'h0A,
                              8'h46, 8'h46, 8'h20, 8'h0D, 8'h0A};
`endif

    initial begin
        int cnt[NCH];
        logic [7:0] first[NCH];
        logic [NCH-1:0] m;
        int gap;
        int seen;
        int nb;
        int k;

        #2;
        do_reset();

        // Single byte 0x3A on ch0, idle-timeout line end.
        cnt = '{1, 0, 0};
        first = '{8'h3A, 8'h00, 8'h00};
        load(cnt, 1'b0, first, m);
        drain(1'b0, -1);
        chk("t1_len", log_q.size(), 5 + TAGN);
        for (int i = 0; i < 5 + TAGN && i < log_q.size(); i++) chk("t1_char", log_q[i], lit1[i]);
        if (log_q.size() >= 5 + TAGN) begin
            gap = log_t[TAGN+3] - log_t[TAGN+2];
            chk("t1_idle_gap_in_range", (gap >= IDLE) && (gap <= IDLE + 4), 1);
        end

        // Two channels pushed together; ch0 is served first after reset.
        do_reset();
        cnt = '{1, 1, 0};
        first = '{8'h01, 8'hFF, 8'h00};
        load(cnt, 1'b0, first, m);
        drain(1'b1, -1);
        chk("t2_len", log_q.size(), 10 + 2 * TAGN);
        for (int i = 0; i < 10 + 2 * TAGN && i < log_q.size(); i++) chk("t2_char", log_q[i], lit2[i]);

        // LMAX+1 bytes on ch1: forced line break after LMAX bytes.
        log_q.delete();
        log_t.delete();
        cnt = '{0, LMAX + 1, 0};
        load(cnt, 1'b1, first, m);
        drain(1'b1, -1);
        chk("t3_len", log_q.size(), 3 * (LMAX + 1) + 4 + 2 * TAGN);
        if (log_q.size() > TAGN + 3 * LMAX + 1) begin
            chk("t3_cr_after_lmax", log_q[TAGN + 3 * LMAX], 8'h0D);
            chk("t3_lf_after_lmax", log_q[TAGN + 3 * LMAX + 1], 8'h0A);
        end

        // Overflow on ch0, clear, then clear colliding with a new overflow.
        log_q.delete();
        log_t.delete();
        cnt = '{DEPTH + 1, 0, 0};
        load(cnt, 1'b1, first, m);
        chk("t4_ovf0", ovf_o[0], 1);
        pulse_clear();
        rx_en_i[0] = 1'b1;
        rx_data_i[7:0] = 8'h99;
        ovf_clr_i = 1'b1;
        tick();
        rx_en_i = '0;
        ovf_clr_i = 1'b0;
        chk("t4_ovf_set_wins", ovf_o, 3'b001);
        pulse_clear();
        drain(1'b1, -1);
        chk("t4_len", log_q.size(), 3 * DEPTH + 4 + 2 * TAGN);

        // Long busy stall in mid-line.
        cnt = '{0, 0, LMAX};
        load(cnt, 1'b1, first, m);
        drain(1'b1, n_rx + 4);

        // Reset while the low nibble is pending.
        do_reset();
        cnt = '{3, 0, 0};
        load(cnt, 1'b1, first, m);
        tx_busy_i = 1'b0;
        seen = 0;
        k = 0;
        while (seen < TAGN + 1 && k < 500) begin
            tick();
            k++;
            if (tx_en_o) seen++;
        end
        chk("t6_reached_lo", seen, TAGN + 1);
        rst_ni = 1'b0;
        #1;
        chk("t6_tx_en_async_clear", tx_en_o, 0);
        chk("t6_tx_data_clear", tx_data_o, 8'h00);
        clear_model();
        repeat (2) tick();
        rst_ni = 1'b1;
        nb = n_rx;
        repeat (IDLE + 20) tick();
        chk("t6_quiet_after_reset", n_rx, nb);
        cnt = '{0, 1, 0};
        load(cnt, 1'b1, first, m);
        drain(1'b1, -1);

        // Randomized batches.
        for (int it = 0; it < 15; it++) begin
            for (int c = 0; c < NCH; c++) cnt[c] = int'($urandom_range(0, DEPTH + 1));
            load(cnt, 1'b1, first, m);
            if (m != '0) pulse_clear();
            drain(1'b1, ($urandom_range(0, 1) == 1) ? n_rx + int'($urandom_range(1, 20)) : -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
